// File: rtl/bla_sub8_pipe_if.sv
// Handshake bundle for the borrow-lookahead subtractor: operand side and result side.
// Latency: none (wires only).
// Backpressure: carries in_ready/out_ready; the master drives operands and out_ready.
//
// Signals:
//   in_valid/in_ready, in_a, in_b, in_bin                 operand beat
//   out_valid/out_ready, out_diff, out_bout, out_zero, out_ovf   result beat
interface bla_sub8_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_diff;
  logic             out_bout;
  logic             out_zero;
  logic             out_ovf;

  // Source/sink side (testbench or upstream/downstream logic).
  modport master (
    output in_valid, in_a, in_b, in_bin, out_ready,
    input  in_ready, out_valid, out_diff, out_bout, out_zero, out_ovf
  );

  // Subtractor side.
  modport slave (
    input  in_valid, in_a, in_b, in_bin, out_ready,
    output in_ready, out_valid, out_diff, out_bout, out_zero, out_ovf
  );
endinterface

// File: rtl/bla_sub8_pipe.sv
// Two-stage borrow-lookahead subtractor: diff = a - b - bin with borrow/zero/overflow flags.
// Latency: 2 cycles from an accepted operand beat to out_valid; 1 beat per cycle sustained.
// Backpressure: out_ready low holds S2, S1 fills, then in_ready drops; at most 2 beats in flight.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (flushes both stages, zeroes outputs)
//   bus (slave)  in_valid/in_ready/in_a/in_b/in_bin, out_valid/out_ready/out_diff/
//                out_bout/out_zero/out_ovf
// Optional feature macro: BLA_SUB_SATURATE_EN -- when defined, a borrowing result is
// clamped to 0 (out_zero follows the clamped value; out_bout/out_ovf stay raw).
module bla_sub8_pipe #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  bla_sub8_pipe_if.slave bus
);

  // Full two-level borrow term for bit i: bin & pb[0..i] | OR_j (gb[j] & pb[j+1..i]).
  // Loops unroll into a flat sum of products, so no borrow ripples through bits.
  function automatic logic borrow_at(input int i,
                                     input logic [WIDTH-1:0] gb,
                                     input logic [WIDTH-1:0] pb,
                                     input logic bin);
    logic acc;
    logic prod;
    prod = bin;
    for (int k = 0; k <= i; k++) prod = prod & pb[k];
    acc = prod;
    for (int j = 0; j <= i; j++) begin
      prod = gb[j];
      for (int k = j + 1; k <= i; k++) prod = prod & pb[k];
      acc = acc | prod;
    end
    return acc;
  endfunction

  // ---------------- Stage 1: generate/propagate ----------------
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_gb_q, s1_gb_d;
  logic [WIDTH-1:0] s1_pb_q, s1_pb_d;
  logic             s1_amsb_q, s1_bmsb_q, s1_bin_q;

  // ---------------- Stage 2: result and flags ----------------
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_diff_q, s2_diff_d;
  logic             s2_bout_q, s2_bout_d;
  logic             s2_zero_q, s2_zero_d;
  logic             s2_ovf_q,  s2_ovf_d;

  logic adv1, adv2;
  logic [WIDTH-1:0] borrow;      // borrow out of each bit
  logic [WIDTH-1:0] borrow_in;   // borrow into each bit
  logic [WIDTH-1:0] diff_raw;

  assign adv2 = ~s2_valid_q | bus.out_ready;
  assign adv1 = ~s1_valid_q | adv2;
  assign bus.in_ready = adv1 & ~rst;

  assign s1_gb_d = ~bus.in_a & bus.in_b;
  assign s1_pb_d = ~(bus.in_a ^ bus.in_b);

  always_comb begin
    borrow = '0;
    for (int i = 0; i < WIDTH; i++) begin
      borrow[i] = borrow_at(i, s1_gb_q, s1_pb_q, s1_bin_q);
    end
  end

  assign borrow_in = {borrow[WIDTH-2:0], s1_bin_q};
  // a ^ b == ~pb, so each diff bit is ~pb ^ borrow-in.
  assign diff_raw  = ~s1_pb_q ^ borrow_in;
  assign s2_bout_d = borrow[WIDTH-1];

`ifdef BLA_SUB_SATURATE_EN
  assign s2_diff_d = s2_bout_d ? '0 : diff_raw;
`else
  assign s2_diff_d = diff_raw;
`endif

  assign s2_zero_d = (s2_diff_d == '0);
  // Signed overflow only when operand signs differ and the raw result sign leaves a's sign.
  assign s2_ovf_d  = (s1_amsb_q != s1_bmsb_q) & (diff_raw[WIDTH-1] != s1_amsb_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_gb_q    <= '0;
      s1_pb_q    <= '0;
      s1_amsb_q  <= 1'b0;
      s1_bmsb_q  <= 1'b0;
      s1_bin_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_diff_q  <= '0;
      s2_bout_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_ovf_q   <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_gb_q   <= s1_gb_d;
          s1_pb_q   <= s1_pb_d;
          s1_amsb_q <= bus.in_a[WIDTH-1];
          s1_bmsb_q <= bus.in_b[WIDTH-1];
          s1_bin_q  <= bus.in_bin;
        end
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_diff_q <= s2_diff_d;
          s2_bout_q <= s2_bout_d;
          s2_zero_q <= s2_zero_d;
          s2_ovf_q  <= s2_ovf_d;
        end
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_diff  = s2_diff_q;
  assign bus.out_bout  = s2_bout_q;
  assign bus.out_zero  = s2_zero_q;
  assign bus.out_ovf   = s2_ovf_q;

endmodule

// File: tb/tb_bla_sub8_pipe.sv
// Directed bench for bla_sub8_pipe: reset state, flag vectors, streaming, stall, mid-flight reset.
// Latency: expects results 2 cycles after acceptance.
// Backpressure: drives out_ready low to fill the pipe and checks in_ready/hold behaviour.
module tb_bla_sub8_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  bla_sub8_pipe_if #(.WIDTH(8)) bus();

  bla_sub8_pipe #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Presents one beat into an empty pipe and returns what emerges plus the latency in cycles.
  task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          output logic [7:0] d, output logic bo, output logic z,
                          output logic o, output int lat);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_bin    = bin;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = -1;
    d = '0; bo = 1'b0; z = 1'b0; o = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = c;
        d = bus.out_diff; bo = bus.out_bout; z = bus.out_zero; o = bus.out_ovf;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_bin = 1'b0; bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++; if ({bus.out_diff, bus.out_bout, bus.out_zero, bus.out_ovf} !== 11'd0) begin
      failures++; $display("FAIL reset_outputs diff=%h bout=%b zero=%b ovf=%b want all 0",
                           bus.out_diff, bus.out_bout, bus.out_zero, bus.out_ovf); end
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_vectors();
    logic [7:0] va [6];
    logic [7:0] vb [6];
    logic       vc [6];
    logic [7:0] ed [6];
    logic       eb [6];
    logic       ez [6];
    logic       eo [6];
    logic [7:0] d;
    logic bo, z, o;
    int lat;
    va = '{8'h05, 8'h00, 8'h80, 8'h10, 8'h55, 8'h7F};
    vb = '{8'h03, 8'h01, 8'h01, 8'h0F, 8'h55, 8'hFF};
    vc = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
    eb = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
    eo = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
`ifdef BLA_SUB_SATURATE_EN
    ed = '{8'h02, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00};
    ez = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1};
`else
    ed = '{8'h02, 8'hFF, 8'h7F, 8'h00, 8'hFF, 8'h80};
    ez = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
`endif
    for (int i = 0; i < 6; i++) begin
      send_one(va[i], vb[i], vc[i], d, bo, z, o, lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL vec%0d_latency got=%0d want=2", i, lat); end
      checks++; if (d !== ed[i]) begin failures++; $display("FAIL vec%0d_diff got=%h want=%h", i, d, ed[i]); end
      checks++; if (bo !== eb[i]) begin failures++; $display("FAIL vec%0d_bout got=%b want=%b", i, bo, eb[i]); end
      checks++; if (z !== ez[i]) begin failures++; $display("FAIL vec%0d_zero got=%b want=%b", i, z, ez[i]); end
      checks++; if (o !== eo[i]) begin failures++; $display("FAIL vec%0d_ovf got=%b want=%b", i, o, eo[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [5];
    logic [7:0] vb [5];
    logic       vc [5];
    logic [7:0] ed [5];
    logic       eb [5];
    int sent = 0;
    int got = 0;
    int first_out = -1;
    int last_out = -1;
    va = '{8'h05, 8'hFF, 8'h00, 8'hAA, 8'h3C};
    vb = '{8'h03, 8'h01, 8'h00, 8'h55, 8'hC3};
    vc = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
    eb = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
`ifdef BLA_SUB_SATURATE_EN
    ed = '{8'h02, 8'hFD, 8'h00, 8'h55, 8'h00};
`else
    ed = '{8'h02, 8'hFD, 8'hFF, 8'h55, 8'h79};
`endif
    for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      if (sent < 5) begin
        bus.in_valid = 1'b1; bus.in_a = va[sent]; bus.in_b = vb[sent]; bus.in_bin = vc[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.in_valid) begin
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", cyc, bus.in_ready); end
        if (bus.in_ready) sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        checks++; if (bus.out_diff !== ed[got]) begin failures++; $display("FAIL b2b_diff%0d got=%h want=%h", got, bus.out_diff, ed[got]); end
        checks++; if (bus.out_bout !== eb[got]) begin failures++; $display("FAIL b2b_bout%0d got=%b want=%b", got, bus.out_bout, eb[got]); end
        got++;
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (got !== 5) begin failures++; $display("FAIL b2b_count got=%0d want=5", got); end
    checks++; if (first_out !== 2) begin failures++; $display("FAIL b2b_first_latency got=%0d want=2", first_out); end
    checks++; if (last_out !== 6) begin failures++; $display("FAIL b2b_last_cycle got=%0d want=6", last_out); end
  endtask

  task automatic test_backpressure();
    logic [7:0] ed [4];
    logic [7:0] held = '0;
    logic stalled = 1'b0;
    int acc = 0;
    int got = 0;
    ed = '{8'h0F, 8'h10, 8'h11, 8'h12};
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_diff !== held) begin
          failures++; $display("FAIL bp_hold valid=%b diff=%h want valid=1 diff=%h", bus.out_valid, bus.out_diff, held); end
      end
      bus.out_ready = (cyc >= 3);
      if (acc < 4) begin
        bus.in_valid = 1'b1; bus.in_a = 8'h10 + 8'(acc); bus.in_b = 8'h01; bus.in_bin = 1'b0;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (cyc == 2) begin
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_full got=%b want=0", bus.in_ready); end
        checks++; if (acc !== 2) begin failures++; $display("FAIL bp_accepted_before_full got=%0d want=2", acc); end
      end
      if (bus.in_valid && bus.in_ready) acc++;
      if (bus.out_valid && bus.out_ready) begin
        checks++; if (bus.out_diff !== ed[got]) begin failures++; $display("FAIL bp_order%0d got=%h want=%h", got, bus.out_diff, ed[got]); end
        got++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      held = bus.out_diff;
    end
    bus.in_valid = 1'b0;
    checks++; if (got !== 4) begin failures++; $display("FAIL bp_results got=%0d want=4", got); end
    checks++; if (acc !== 4) begin failures++; $display("FAIL bp_accepted got=%0d want=4", acc); end
  endtask

  task automatic test_reset_midflight();
    logic [7:0] d;
    logic bo, z, o;
    int lat;
    // Load S2 with 0x00-0x01 (borrow set) and S1 with 0x80-0x01 while stalled.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = 8'h00; bus.in_b = 8'h01; bus.in_bin = 1'b0;
    @(negedge clk);
    bus.in_a = 8'h80;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_bout !== 1'b1) begin
      failures++; $display("FAIL rstmid_loaded valid=%b bout=%b want 1 1", bus.out_valid, bus.out_bout); end
    rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rstmid_in_ready_during got=%b want=0", bus.in_ready); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b want=0", bus.out_valid); end
    checks++; if ({bus.out_diff, bus.out_bout, bus.out_zero, bus.out_ovf} !== 11'd0) begin
      failures++; $display("FAIL rstmid_outputs diff=%h bout=%b zero=%b ovf=%b want all 0",
                           bus.out_diff, bus.out_bout, bus.out_zero, bus.out_ovf); end
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready_after got=%b want=1", bus.in_ready); end
    send_one(8'h20, 8'h05, 1'b0, d, bo, z, o, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL rstmid_fresh_latency got=%0d want=2", lat); end
    checks++; if (d !== 8'h1B || bo !== 1'b0) begin failures++; $display("FAIL rstmid_fresh diff=%h bout=%b want 1b 0", d, bo); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bla_sub8_pipe.md
Name: bla_sub8_pipe

Overview:
- Pipelined WIDTH-bit subtractor, the inverse companion to the team's carry-lookahead adder.
- Computes diff = a - b - bin using borrow-lookahead: per-bit borrow-generate gb = ~a & b, borrow-propagate pb = ~(a ^ b), flat two-level borrow equations.
- Two register stages with valid/ready handshake and full backpressure; one result per cycle sustained.
- Sits beside the adder in the ALU datapath, feeding compare/branch logic via its flags.

Parameters:
- WIDTH, 8, operand and result width in bits (the lookahead equations are written flat for any WIDTH >= 2).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  WIDTH  minuend.
- in_b  input  WIDTH  subtrahend.
- in_bin  input  1  borrow-in.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- out_diff  output  WIDTH  a - b - bin modulo 2^WIDTH.
- out_bout  output  1  unsigned borrow-out (1 when a < b + bin).
- out_zero  output  1  out_diff == 0.
- out_ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset: synchronous, active-high, on clk. While rst is high at an edge: s1_valid = s2_valid = 0; out_valid, out_diff, out_bout, out_zero, out_ovf all 0; in_ready = 0 while rst is asserted.
- Stage 1 (S1) registers gb, pb, the a and b sign bits, and bin.
- Stage 2 (S2) registers the borrow chain b[i] = gb[i] | pb[i] & b[i-1] (b[-1] = bin), expanded fully in two-level AND-OR form with no ripple. It also registers diff[i] = ~pb[i] ^ b[i-1], bout = b[WIDTH-1], zero, and ovf = (a_msb != b_msb) & (diff_msb != a_msb).
- Handshake: a beat transfers on an edge where valid & ready. Inputs are sampled only on an in transfer. While out_valid is high and out_ready is low, the outputs hold stable.
- Advance rules: adv2 = ~s2_valid | out_ready; adv1 = ~s1_valid | adv2; in_ready = adv1 & ~rst (combinational). When an stage advances with no upstream data, its valid clears.
- Latency: exactly 2 cycles from an in transfer to out_valid when out_ready stays high; throughput 1 beat per cycle.
- Backpressure: with out_ready low, S2 holds, S1 fills, then in_ready drops. At most 2 beats are in flight. No beat is dropped or duplicated, and order is preserved.
- Simultaneous events: an in transfer and an out transfer in the same cycle while full are legal and keep the pipeline full.
- Reset mid-operation flushes both stages. The next cycle shows out_valid = 0 and in_ready = 1 once rst is low.
- Wrap-around: 0 - 1 gives all ones with bout = 1. bin = 1 with a = b gives all ones with bout = 1.

Optional Feature:
- Macro BLA_SUB_SATURATE_EN.
- When defined: if bout = 1, out_diff is forced to 0 (unsigned saturation). out_zero reflects the saturated value (so it is 1). out_bout and out_ovf still report the raw result.
- When undefined: out_diff is the modulo result. No extra logic is present.

Test Plan:
- in_a=0x05, in_b=0x03, in_bin=0, out_ready=1 -> 2 cycles later out_valid=1, out_diff=0x02, out_bout=0, out_zero=0, out_ovf=0.
- in_a=0x00, in_b=0x01 -> out_diff=0xFF, out_bout=1; with BLA_SUB_SATURATE_EN: out_diff=0x00, out_zero=1, out_bout=1.
- in_a=0x80, in_b=0x01 -> out_diff=0x7F, out_ovf=1, out_bout=0.
- in_a=0x10, in_b=0x0F, in_bin=1 -> out_diff=0x00, out_zero=1, out_bout=0.
- Stream 4 beats (a = 0x10..0x13, b = 0x01) with out_ready low for 3 cycles -> in_ready=0 after 2 beats are accepted. Once released, results 0x0F, 0x10, 0x11, 0x12 arrive in order, outputs stay stable while stalled, and nothing is lost.
- Assert rst for 1 cycle with 2 beats in flight -> next cycle out_valid=0 and all outputs 0. After rst deasserts, in_ready=1 and a fresh beat returns a correct result with 2-cycle latency.
